// File: rtl/serial_subtractor_if.sv
// Start/busy/done handshake bundle for the bit-serial subtractor.
// Carries start, operands A/B, and busy, done, DIFF and borrow_out back.
interface serial_subtractor_if #(
  parameter int WIDTH = 4
);
  logic             start;
  logic [WIDTH-1:0] A;
  logic [WIDTH-1:0] B;
  logic             busy;
  logic             done;
  logic [WIDTH-1:0] DIFF;
  logic             borrow_out;

  modport master (
    output start, A, B,
    input  busy, done, DIFF, borrow_out
  );

  modport slave (
    input  start, A, B,
    output busy, done, DIFF, borrow_out
  );
endinterface

// File: rtl/serial_subtractor.sv
// Bit-serial subtractor: DIFF = A - B, LSB first, one bit per clock.
// Ports: clk, rst (sync, active-high), bus (slave: start/A/B in;
// busy/done/DIFF/borrow_out out). Macro SERIAL_SUB_SATURATE_EN clamps
// an underflowing DIFF to 0 while borrow_out still reports 1.
module serial_subtractor #(
  parameter int WIDTH = 4
) (
  input  logic                  clk,
  input  logic                  rst,
  serial_subtractor_if.slave    bus
);

  localparam int CW = $clog2(WIDTH) + 1;

  typedef enum logic [1:0] {
    IDLE = 2'd0,
    RUN  = 2'd1,
    DONE = 2'd2
  } state_t;

  state_t           state;
  state_t           state_n;
  logic [WIDTH-1:0] a_q;
  logic [WIDTH-1:0] b_q;
  logic [WIDTH-1:0] res_q;
  logic [WIDTH-1:0] diff_q;
  logic             br_q;
  logic             bor_q;
  logic [CW-1:0]    cnt_q;

  logic             a0;
  logic             b0;
  logic             d;
  logic             br_n;
  logic [WIDTH-1:0] res_n;
  logic             last;

  assign a0    = a_q[0];
  assign b0    = b_q[0];
  assign d     = a0 ^ b0 ^ br_q;
  assign br_n  = (~a0 & b0) | (~(a0 ^ b0) & br_q);
  assign res_n = {d, res_q[WIDTH-1:1]};
  assign last  = (cnt_q == CW'(WIDTH - 1));

  always_ff @(posedge clk) begin
    if (rst) begin
      state <= IDLE;
    end else begin
      state <= state_n;
    end
  end

  always_comb begin
    state_n = state;
    unique case (state)
      IDLE: if (bus.start) state_n = RUN;
      RUN:  if (last) state_n = DONE;
      DONE: state_n = IDLE;
      default: state_n = IDLE;
    endcase
  end

  // Result is published on the final RUN edge so it is
  // already valid during the single DONE cycle.
  always_ff @(posedge clk) begin
    if (rst) begin
      a_q    <= '0;
      b_q    <= '0;
      res_q  <= '0;
      br_q   <= 1'b0;
      cnt_q  <= '0;
      diff_q <= '0;
      bor_q  <= 1'b0;
    end else begin
      unique case (state)
        IDLE: begin
          if (bus.start) begin
            a_q   <= bus.A;
            b_q   <= bus.B;
            res_q <= '0;
            br_q  <= 1'b0;
            cnt_q <= '0;
          end
        end
        RUN: begin
          a_q   <= a_q >> 1;
          b_q   <= b_q >> 1;
          res_q <= res_n;
          br_q  <= br_n;
          cnt_q <= cnt_q + 1'b1;
          if (last) begin
`ifdef SERIAL_SUB_SATURATE_EN
            diff_q <= br_n ? '0 : res_n;
`else
            diff_q <= res_n;
`endif
            bor_q  <= br_n;
          end
        end
        default: begin
        end
      endcase
    end
  end

  assign bus.busy       = (state == RUN);
  assign bus.done       = (state == DONE);
  assign bus.DIFF       = diff_q;
  assign bus.borrow_out = bor_q;

endmodule

// File: tb/tb_serial_subtractor.sv
// Self-checking bench for serial_subtractor (WIDTH=4).
// Directed cases plus random operands against an arithmetic model.
module tb_serial_subtractor;

  localparam int W = 4;

  logic clk = 1'b0;
  logic rst = 1'b1;
  int   checks = 0;
  int   errors = 0;

  logic [W-1:0] exp_diff = '0;
  logic         exp_bor  = 1'b0;

  serial_subtractor_if #(.WIDTH(W)) bus ();

  serial_subtractor #(.WIDTH(W)) dut (
    .clk (clk),
    .rst (rst),
    .bus (bus)
  );

  always #5 clk = ~clk;

  task automatic chk(input string tag,
                     input logic [31:0] obs,
                     input logic [31:0] exp);
    checks++;
    assert (obs === exp) else begin
      errors++;
      $error("FAIL %s observed=%0h expected=%0h", tag, obs, exp);
    end
  endtask

  function automatic logic [W:0] model(input int a, input int b);
    int          d;
    logic        bo;
    logic [W-1:0] r;
    bo = (a < b);
    d  = a - b;
    if (d < 0) d = d + (1 << W);
    r = W'(d);
`ifdef SERIAL_SUB_SATURATE_EN
    if (bo) r = '0;
`endif
    return {bo, r};
  endfunction

  // Caller is at a negedge with the DUT idle. Returns at the
  // negedge one cycle after done, so a further call is back-to-back.
  task automatic do_op(input int a, input int b,
                       input bit inject, input string tag);
    logic [W:0] m;
    int done_k;
    int ndone;
    int nbusy;
    m = model(a, b);
    done_k = 0;
    ndone  = 0;
    nbusy  = 0;
    bus.A     = W'(a);
    bus.B     = W'(b);
    bus.start = 1'b1;
    for (int k = 1; k <= 6; k++) begin
      @(negedge clk);
      if (k == 1) begin
        bus.start = 1'b0;
        bus.A = W'($urandom_range(0, 15));
        bus.B = W'($urandom_range(0, 15));
      end
      if (inject && k == 2) begin
        bus.A = W'(1);
        bus.B = W'(2);
        bus.start = 1'b1;
      end
      if (k == 3) bus.start = 1'b0;
      if (bus.busy) nbusy++;
      if (bus.done) begin
        ndone++;
        done_k = k;
      end
      if (k < 5) begin
        chk({tag, "_hold_diff"}, 32'(bus.DIFF), 32'(exp_diff));
      end
    end
    chk({tag, "_done_cycle"}, 32'(done_k), 32'd5);
    chk({tag, "_done_count"}, 32'(ndone), 32'd1);
    chk({tag, "_busy_cycles"}, 32'(nbusy), 32'd4);
    chk({tag, "_diff"}, 32'(bus.DIFF), 32'(m[W-1:0]));
    chk({tag, "_borrow"}, 32'(bus.borrow_out), 32'(m[W]));
    exp_diff = m[W-1:0];
    exp_bor  = m[W];
  endtask

  initial begin
    int ndone;
    bus.start = 1'b0;
    bus.A = '0;
    bus.B = '0;
    rst = 1'b1;
    repeat (2) @(negedge clk);
    bus.start = 1'b1;
    @(negedge clk);
    chk("rst_busy", 32'(bus.busy), 32'd0);
    chk("rst_done", 32'(bus.done), 32'd0);
    chk("rst_diff", 32'(bus.DIFF), 32'd0);
    chk("rst_borrow", 32'(bus.borrow_out), 32'd0);
    bus.start = 1'b0;
    rst = 1'b0;
    @(negedge clk);

    do_op(5, 3, 1'b0, "5m3");
    do_op(3, 5, 1'b0, "3m5");
    do_op(15, 15, 1'b0, "eq");
    do_op(0, 0, 1'b0, "zero");
    do_op(0, 15, 1'b0, "0m15");
    do_op(9, 4, 1'b1, "busy_start");

    bus.A = W'(8);
    bus.B = W'(1);
    bus.start = 1'b1;
    @(negedge clk);
    bus.start = 1'b0;
    @(negedge clk);
    rst = 1'b1;
    @(negedge clk);
    rst = 1'b0;
    chk("mid_rst_busy", 32'(bus.busy), 32'd0);
    chk("mid_rst_done", 32'(bus.done), 32'd0);
    chk("mid_rst_diff", 32'(bus.DIFF), 32'd0);
    chk("mid_rst_borrow", 32'(bus.borrow_out), 32'd0);
    exp_diff = '0;
    exp_bor  = 1'b0;
    ndone = 0;
    for (int k = 0; k < 8; k++) begin
      @(negedge clk);
      if (bus.done) ndone++;
    end
    chk("mid_rst_no_done", 32'(ndone), 32'd0);
    do_op(6, 6, 1'b0, "after_rst");

    do_op(7, 2, 1'b0, "b2b_1");
    do_op(2, 7, 1'b0, "b2b_2");

    for (int i = 0; i < 20; i++) begin
      do_op(int'($urandom_range(0, 15)), int'($urandom_range(0, 15)),
            1'($urandom_range(0, 1)), "rand");
    end

    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end

endmodule
